// File: rtl/stepper_pkg.sv
// Shared types and defaults for the stepper move sequencer and its step-rate divider.
package stepper_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RUN    = 2'd2,
    DONE   = 2'd3
  } seq_state_t;

  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_REV = 1'b0;

  localparam int DEFAULT_CLK_DIV     = 10;
  localparam int DEFAULT_DEAD_CYCLES = 20;
  localparam int DEFAULT_STEP_W      = 16;
  localparam int DEFAULT_POS_W       = 16;

  function automatic logic is_moving(input seq_state_t s);
    return (s == SETTLE) || (s == RUN);
  endfunction

endpackage

// File: rtl/step_rate_divider.sv
// Free-running modulo-CLK_DIV counter that flags the last cycle of each step period.
// Held at zero whenever run is low so every move starts on a full period.
module step_rate_divider
  import stepper_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic tick
);

  localparam int CNT_W = $clog2(CLK_DIV);

  logic [CNT_W-1:0] count_q, count_d;
  logic             wrap;

  assign wrap = (count_q == CNT_W'(CLK_DIV - 1));
  assign tick = run && wrap;

  always_comb begin
    count_d = count_q;
    if (!run || wrap) begin
      count_d = '0;
    end else begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/stepper_move_sequencer.sv
// Command stage for the steppermotor block: accepts direction/step-count moves, gates
// dir/enable for exactly that many step periods, tracks position, settles on reversal.
module stepper_move_sequencer
  import stepper_pkg::*;
#(
  parameter int CLK_DIV     = DEFAULT_CLK_DIV,
  parameter int STEP_W      = DEFAULT_STEP_W,
  parameter int POS_W       = DEFAULT_POS_W,
  parameter int DEAD_CYCLES = DEFAULT_DEAD_CYCLES
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_dir,
  input  logic [STEP_W-1:0]       cmd_steps,
  input  logic                    abort,
  output logic                    dir,
  output logic                    enable,
  output logic                    step_tick,
  output logic                    busy,
  output logic                    done,
  output logic                    aborted,
  output logic signed [POS_W-1:0] position
);

  localparam int SETTLE_W = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;

  seq_state_t          state_q, state_d;
  logic                dir_q, dir_d;
  logic                enable_q, enable_d;
  logic                step_tick_q, step_tick_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                aborted_q, aborted_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                abort_flag_q, abort_flag_d;
  logic [POS_W-1:0]    position_q, position_d;
  logic [STEP_W-1:0]   remaining_q, remaining_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;

  logic run;
  logic div_tick;
  logic accept;
  logic final_tick;

  assign run = (state_q == RUN);

  step_rate_divider #(
    .CLK_DIV(CLK_DIV)
  ) u_div (
    .clk  (clk),
    .reset(reset),
    .run  (run),
    .tick (div_tick)
  );

  always_comb begin
    // NOTE: every _d starts from a default so no path through the case can infer a latch.
    state_d      = state_q;
    dir_d        = dir_q;
    position_d   = position_q;
    remaining_d  = remaining_q;
    settle_d     = settle_q;
    abort_flag_d = abort_flag_q;
    step_tick_d  = 1'b0;
    done_d       = 1'b0;
    aborted_d    = 1'b0;

    accept     = cmd_valid && cmd_ready_q;
    final_tick = div_tick && (remaining_q == STEP_W'(1));

    case (state_q)
      IDLE: begin
        if (accept) begin
          abort_flag_d = 1'b0;
          if (cmd_steps == '0) begin
            state_d = DONE;
          end else begin
            remaining_d = cmd_steps;
            if (cmd_dir != dir_q) begin
              dir_d    = cmd_dir;
              settle_d = '0;
              state_d  = SETTLE;
            end else begin
              state_d = RUN;
            end
          end
        end
      end
      SETTLE: begin
        if (abort) begin
          state_d      = DONE;
          abort_flag_d = 1'b1;
          remaining_d  = '0;
        end else if (settle_q == SETTLE_W'(DEAD_CYCLES - 1)) begin
          state_d = RUN;
        end else begin
          settle_d = settle_q + SETTLE_W'(1);
        end
      end
      RUN: begin
        // A tick landing on the abort edge is a completed step and still counts.
        if (div_tick) begin
          step_tick_d = 1'b1;
          remaining_d = remaining_q - STEP_W'(1);
          position_d  = (dir_q == DIR_REV) ? position_q - POS_W'(1) : position_q + POS_W'(1);
        end
        if (final_tick) begin
          state_d = DONE;
        end else if (abort) begin
          state_d      = DONE;
          abort_flag_d = 1'b1;
          remaining_d  = '0;
        end
      end
      DONE: begin
        done_d       = 1'b1;
        aborted_d    = abort_flag_q;
        abort_flag_d = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // enable follows the RUN state one cycle late, so it never overlaps a dir change.
    enable_d    = (state_q == RUN);
    busy_d      = is_moving(state_d);
    cmd_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      state_q      <= IDLE;
      dir_q        <= DIR_FWD;
      enable_q     <= 1'b0;
      step_tick_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      cmd_ready_q  <= 1'b1;
      abort_flag_q <= 1'b0;
      position_q   <= '0;
      remaining_q  <= '0;
      settle_q     <= '0;
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      enable_q     <= enable_d;
      step_tick_q  <= step_tick_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      cmd_ready_q  <= cmd_ready_d;
      abort_flag_q <= abort_flag_d;
      position_q   <= position_d;
      remaining_q  <= remaining_d;
      settle_q     <= settle_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign dir       = dir_q;
  assign enable    = enable_q;
  assign step_tick = step_tick_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign aborted   = aborted_q;
  assign position  = position_q;

endmodule

// File: tb/tb_stepper_move_sequencer.sv
// Randomized and directed bench for stepper_move_sequencer; each move's timing and
// outcome are predicted arithmetically from accept edge, direction and step count.
module tb_stepper_move_sequencer;

  localparam int CLK_DIV     = 10;
  localparam int STEP_W      = 16;
  localparam int POS_W       = 8;   // narrow position so the signed wrap is reachable quickly
  localparam int DEAD_CYCLES = 20;
  localparam int MAX_CYC     = 3000;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_dir = 1'b1;
  logic [STEP_W-1:0] cmd_steps = '0;
  logic              abort = 1'b0;
  logic              cmd_ready, dir, enable, step_tick, busy, done, aborted;
  logic [POS_W-1:0]  position;

  int               n_checks = 0;
  int               n_fail   = 0;
  logic             m_dir;
  logic [POS_W-1:0] m_pos;

  always #5 clk = ~clk;

  stepper_move_sequencer #(
    .CLK_DIV    (CLK_DIV),
    .STEP_W     (STEP_W),
    .POS_W      (POS_W),
    .DEAD_CYCLES(DEAD_CYCLES)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_dir  (cmd_dir),
    .cmd_steps(cmd_steps),
    .abort    (abort),
    .dir      (dir),
    .enable   (enable),
    .step_tick(step_tick),
    .busy     (busy),
    .done     (done),
    .aborted  (aborted),
    .position (position)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic apply_reset();
    reset     = 1'b1;
    cmd_valid = 1'b0;
    abort     = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    m_dir = 1'b1;
    m_pos = '0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_dir"},       dir,       1'b1);
    check({tag, "_enable"},    enable,    1'b0);
    check({tag, "_position"},  position,  '0);
    check({tag, "_cmd_ready"}, cmd_ready, 1'b1);
    check({tag, "_busy"},      busy,      1'b0);
    check({tag, "_flags"},     {step_tick, done, aborted}, 3'b000);
  endtask

  // abort_at: edge index (accept edge = 0) at which abort is sampled high; <=0 means none.
  // hold: leave cmd_valid asserted through the move so the same command is offered again.
  task automatic run_cmd(input logic d, input int steps, input int abort_at, input bit hold);
    int   guard, lead, final_e, completed, exp_ticks, exp_done, exp_en;
    int   ticks, tick_err, en_cnt, first_en, dir_err, ready_err, done_n;
    logic exp_ab, got_ab, new_dir, busy0, dir0;

    guard = 0;
    while (cmd_ready !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("ready_wait", cmd_ready, 1'b1);

    new_dir = (steps != 0) ? d : m_dir;
    lead    = (steps != 0 && d != m_dir) ? DEAD_CYCLES : 0;
    final_e = lead + steps * CLK_DIV;
    exp_ab  = 1'b0;
    if (steps == 0) begin
      exp_ticks = 0;
      exp_done  = 1;
    end else begin
      exp_ticks = steps;
      exp_done  = final_e + 1;
      if (abort_at >= 1 && abort_at <= final_e) begin
        completed = (abort_at < lead) ? 0 : (abort_at - lead) / CLK_DIV;
        if (completed < steps) begin
          exp_ticks = completed;
          exp_done  = abort_at + 1;
          exp_ab    = 1'b1;
        end
      end
    end
    exp_en = (steps == 0 || exp_done - 1 - lead < 0) ? 0 : exp_done - 1 - lead;

    cmd_valid = 1'b1;
    cmd_dir   = d;
    cmd_steps = STEP_W'(steps);

    ticks = 0; tick_err = 0; en_cnt = 0; first_en = -1; dir_err = 0; ready_err = 0;
    done_n = -1; got_ab = 1'b0; busy0 = 1'b0; dir0 = 1'b0;
    for (int n = 0; n < MAX_CYC; n++) begin
      @(negedge clk);
      if (!hold) cmd_valid = 1'b0;
      abort = (n + 1 == abort_at);
      if (n == 0) begin
        busy0 = busy;
        dir0  = dir;
      end
      if (step_tick) begin
        ticks++;
        if (n != lead + ticks * CLK_DIV) tick_err++;
      end
      if (enable) begin
        en_cnt++;
        if (first_en < 0) first_en = n;
        if (dir !== new_dir) dir_err++;
      end
      if (done) begin
        done_n = n;
        got_ab = aborted;
        break;
      end
      if (cmd_ready) ready_err++;
    end
    abort = 1'b0;

    m_dir = new_dir;
    if (d) m_pos = m_pos + POS_W'(exp_ticks);
    else   m_pos = m_pos - POS_W'(exp_ticks);

    check("done_cycle",   done_n,    exp_done);
    check("aborted",      got_ab,    exp_ab);
    check("tick_count",   ticks,     exp_ticks);
    check("tick_spacing", tick_err,  0);
    check("enable_count", en_cnt,    exp_en);
    if (exp_en > 0) check("enable_first", first_en, lead + 1);
    check("dir_stable",   dir_err,   0);
    check("dir_at_accept", dir0,     new_dir);
    check("busy_at_accept", busy0,   steps != 0);
    check("ready_low",    ready_err, 0);
    check("position",     position,  m_pos);
    if (!hold) begin
      @(negedge clk);
      check("done_pulse",  done,      1'b0);
      check("ready_after", cmd_ready, 1'b1);
      check("enable_idle", enable,    1'b0);
    end
  endtask

  task automatic midrun_reset();
    cmd_valid = 1'b1;
    cmd_dir   = m_dir;
    cmd_steps = STEP_W'(4);
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
    end
    check("midrun_enable", enable, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check_reset_values("midrun_reset");
    reset = 1'b0;
    m_dir = 1'b1;
    m_pos = '0;
    @(negedge clk);
  endtask

  initial begin
    logic d;
    int   s, a;
    bit   h;

    apply_reset();
    check_reset_values("reset");

    run_cmd(1'b1, 3, -1, 1'b0);   // same direction, 3 steps
    run_cmd(1'b0, 2, -1, 1'b0);   // reversal with settle gap
    run_cmd(1'b1, 0, -1, 1'b0);   // zero steps: dir must stay put
    run_cmd(1'b1, 5, 41, 1'b0);   // reversal, abort just after the 2nd tick
    run_cmd(1'b1, 2, 20, 1'b1);   // abort on the final tick, valid held through RUN
    run_cmd(1'b1, 1, -1, 1'b0);

    apply_reset();
    run_cmd(1'b1, 127, -1, 1'b0);
    run_cmd(1'b1, 1, -1, 1'b0);
    check("wrap_value", position, 8'h80);
    midrun_reset();

    for (int i = 0; i < 40; i++) begin
      d = 1'($urandom_range(0, 1));
      s = int'($urandom_range(0, 6));
      a = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(1, 90));
      h = (i < 39) && ($urandom_range(0, 3) == 0);
      run_cmd(d, s, a, h);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
